// File: rtl/mat_pkg.sv
// Shared constants, FSM state encoding and position-vector helper for the
// matched-feature centroid stage.
package mat_pkg;

  localparam int FRAME_W = 160;
  localparam int FRAME_H = 120;
  localparam int ADDR_W  = 15;
  localparam int MAX_PTS = 16;
  localparam int MIN_PTS = 4;
  localparam int AVG_W   = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CONV,
    AVGX,
    AVGY,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] entry(input logic [MAX_PTS*ADDR_W-1:0] vec,
                                              input logic [3:0]                  i);
    return vec[ADDR_W*int'(i) +: ADDR_W];
  endfunction

endpackage

// File: rtl/mat_seqdiv.sv
// Restoring divider, one quotient bit per cycle. nbits_i selects how many low
// dividend bits take part, so one instance serves both wide and narrow divides.
module mat_seqdiv #(
  parameter int W  = 15,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] nbits_i,
  input  logic [W-1:0]  dividend_i,
  input  logic [W-1:0]  divisor_i,
  output logic          done_o,
  output logic [W-1:0]  quotient_o,
  output logic [W-1:0]  remainder_o
);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0]  src_rem, src_quo;
  logic [W:0]    shifted;
  logic          ge;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  // The issue cycle already retires the first bit, so the result is usable
  // exactly nbits_i cycles after start.
  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? (dividend_i << (CW'(W) - nbits_i)) : quo_q;
    shifted = {src_rem, src_quo[W-1]};
    ge      = shifted >= {1'b0, divisor_i};
    rem_d   = ge ? W'(shifted - {1'b0, divisor_i}) : shifted[W-1:0];
    quo_d   = {src_quo[W-2:0], ge};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= nbits_i - 1'b1;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
        rem_q <= rem_d;
        quo_q <= quo_d;
      end
    end
  end

  assign done_o      = active_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mat_centroid.sv
// Centroid of matched feature addresses and its signed offset from frame centre.
// Handshake: start is a one-cycle request taken only in IDLE with isMatching=1; done pulses once per accepted request.
module mat_centroid
  import mat_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      isMatching,
  input  logic [4:0]                matchCount,
  input  logic [MAX_PTS*ADDR_W-1:0] position,
  output logic                      busy,
  output logic                      done,
  output logic                      posValid,
  output logic [7:0]                centroidX,
  output logic [6:0]                centroidY,
  output logic [8:0]                offsetX,
  output logic [7:0]                offsetY
);

  state_t                    state_q, state_d;
  logic [MAX_PTS*ADDR_W-1:0] pos_q, pos_d;
  logic [4:0]                n_q, n_d, idx_q, idx_d, vcnt_q, vcnt_d;
  logic [11:0]               sum_x_q, sum_x_d;
  logic [10:0]               sum_y_q, sum_y_d;
  logic [7:0]                avg_x_q, avg_x_d;
  logic [6:0]                avg_y_q, avg_y_d;
  logic                      issue_q, issue_d, ok_q, ok_d;
  logic                      busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [7:0]                cx_q, cx_d;
  logic [6:0]                cy_q, cy_d;
  logic [8:0]                ox_q, ox_d;
  logic [7:0]                oy_q, oy_d;

  logic                      div_start, div_done;
  logic [3:0]                div_bits;
  logic [ADDR_W-1:0]         div_a, div_b, div_quo, div_rem;
  logic [4:0]                n_clamp;
  logic [ADDR_W-1:0]         cur_addr;

  assign n_clamp  = (matchCount > 5'(MAX_PTS)) ? 5'(MAX_PTS) : matchCount;
  assign cur_addr = entry(pos_q, idx_q[3:0]);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    n_d       = n_q;
    idx_d     = idx_q;
    vcnt_d    = vcnt_q;
    sum_x_d   = sum_x_q;
    sum_y_d   = sum_y_q;
    avg_x_d   = avg_x_q;
    avg_y_d   = avg_y_q;
    issue_d   = issue_q;
    ok_d      = ok_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    div_start = 1'b0;
    div_bits  = 4'(ADDR_W);
    div_a     = cur_addr;
    div_b     = ADDR_W'(FRAME_W);
    case (state_q)
      IDLE: begin
        if (start && isMatching) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      LOAD: begin
        pos_d   = position;
        n_d     = n_clamp;
        idx_d   = '0;
        vcnt_d  = '0;
        sum_x_d = '0;
        sum_y_d = '0;
        issue_d = 1'b0;
        // Entry 0 is issued straight from the input while it is being latched.
        if (n_clamp >= 5'(MIN_PTS)) begin
          div_start = 1'b1;
          div_a     = entry(position, 4'd0);
          state_d   = CONV;
        end else begin
          ok_d    = 1'b0;
          state_d = DONE;
        end
      end
      CONV: begin
        if (issue_q) begin
          div_start = 1'b1;
          issue_d   = 1'b0;
        end else if (div_done) begin
          if (cur_addr < ADDR_W'(FRAME_W * FRAME_H)) begin
            sum_y_d = sum_y_q + 11'(div_quo);
            sum_x_d = sum_x_q + 12'(div_rem);
            vcnt_d  = vcnt_q + 5'd1;
          end
          idx_d   = idx_q + 5'd1;
          issue_d = 1'b1;
          if (idx_q + 5'd1 == n_q) state_d = AVGX;
        end
      end
      AVGX: begin
        div_bits = 4'(AVG_W);
        div_a    = ADDR_W'(sum_x_q);
        div_b    = ADDR_W'(vcnt_q);
        if (issue_q) begin
          if (vcnt_q < 5'(MIN_PTS)) begin
            ok_d    = 1'b0;
            state_d = DONE;
          end else begin
            div_start = 1'b1;
            issue_d   = 1'b0;
          end
        end else if (div_done) begin
          avg_x_d = 8'(div_quo);
          issue_d = 1'b1;
          state_d = AVGY;
        end
      end
      AVGY: begin
        div_bits = 4'(AVG_W);
        div_a    = ADDR_W'(sum_y_q);
        div_b    = ADDR_W'(vcnt_q);
        if (issue_q) begin
          div_start = 1'b1;
          issue_d   = 1'b0;
        end else if (div_done) begin
          avg_y_d = 7'(div_quo);
          ok_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        valid_d = ok_q;
        cx_d    = ok_q ? avg_x_q : '0;
        cy_d    = ok_q ? avg_y_q : '0;
        ox_d    = ok_q ? ({1'b0, avg_x_q} - 9'(FRAME_W / 2)) : '0;
        oy_d    = ok_q ? ({1'b0, avg_y_q} - 8'(FRAME_H / 2)) : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      vcnt_q  <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      avg_x_q <= '0;
      avg_y_q <= '0;
      issue_q <= 1'b0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      vcnt_q  <= vcnt_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      avg_x_q <= avg_x_d;
      avg_y_q <= avg_y_d;
      issue_q <= issue_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  mat_seqdiv #(.W(ADDR_W)) u_div (
    .clk_i       (clock),
    .rst_i       (reset),
    .start_i     (div_start),
    .nbits_i     (div_bits),
    .dividend_i  (div_a),
    .divisor_i   (div_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign posValid  = valid_q;
  assign centroidX = cx_q;
  assign centroidY = cy_q;
  assign offsetX   = ox_q;
  assign offsetY   = oy_q;

endmodule

// File: tb/tb_mat_centroid.sv
// Bench for mat_centroid: directed cases plus randomized requests against a
// plain-arithmetic centroid/latency model.
module tb_mat_centroid;

  logic         clock = 1'b0;
  logic         reset, start, isMatching;
  logic [4:0]   matchCount;
  logic [239:0] position;
  logic         busy, done, posValid;
  logic [7:0]   centroidX;
  logic [6:0]   centroidY;
  logic [8:0]   offsetX;
  logic [7:0]   offsetY;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [32:0]  exp_q[$];
  int           lat_q[$];
  logic [32:0]  last_exp;
  logic [239:0] pv;

  mat_centroid dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .isMatching (isMatching),
    .matchCount (matchCount),
    .position   (position),
    .busy       (busy),
    .done       (done),
    .posValid   (posValid),
    .centroidX  (centroidX),
    .centroidY  (centroidY),
    .offsetX    (offsetX),
    .offsetY    (offsetY)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] outs();
    return {posValid, centroidX, centroidY, offsetX, offsetY};
  endfunction

  // Reference: n clamps to 16; valid entries are addresses below 160*120;
  // centroid is the truncated mean, offsets relative to (80,60).
  function automatic logic [32:0] model(input logic [4:0] mc, input logic [239:0] v,
                                        output int lat);
    int n, cnt, sx, sy, a, cx, cy;
    n = (mc > 5'd16) ? 16 : int'(mc);
    if (n < 4) begin
      lat = 2;
      return '0;
    end
    cnt = 0; sx = 0; sy = 0;
    for (int i = 0; i < n; i++) begin
      a = int'(v[15*i +: 15]);
      if (a < 160 * 120) begin
        sx += a % 160;
        sy += a / 160;
        cnt++;
      end
    end
    if (cnt < 4) begin
      lat = 16 * n + 2;
      return '0;
    end
    lat = 16 * n + 27;
    cx = sx / cnt;
    cy = sy / cnt;
    return {1'b1, 8'(cx), 7'(cy), 9'(cx - 80), 8'(cy - 60)};
  endfunction

  // ---------------- drivers ----------------
  task automatic put(input int i, input int a);
    pv[15*i +: 15] = 15'(a);
  endtask

  task automatic fill_junk();
    for (int i = 0; i < 16; i++) put(i, int'($urandom_range(0, 32767)));
  endtask

  task automatic put_square();
    put(0, 1610); put(1, 1620); put(2, 3210); put(3, 3220);
  endtask

  task automatic send_req(input string tag, input logic [4:0] mc, input int extra_at);
    int          lat, exp_lat, got_lat, dones, busy_bad, k;
    logic [32:0] exp_r, at_done;
    exp_r = model(mc, pv, lat);
    exp_q.push_back(exp_r);
    lat_q.push_back(lat);
    @(negedge clock);
    matchCount = mc; position = pv; isMatching = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    got_lat = -1; dones = 0; busy_bad = 0; at_done = '0; k = 0;
    if (busy !== 1'b1) busy_bad++;
    while (k < 400 && (got_lat < 0 || k < got_lat + 3)) begin
      k++;
      @(negedge clock);
      start = (k == extra_at);
      if (k == 2) begin
        position   = ~pv;
        matchCount = ~mc;
      end
      @(posedge clock); #1;
      if (done === 1'b1) begin
        dones++;
        if (got_lat < 0) begin
          got_lat = k;
          at_done = outs();
          if (busy !== 1'b0) busy_bad++;
        end
      end else if (got_lat < 0 && busy !== 1'b1) begin
        busy_bad++;
      end
    end
    exp_r   = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    last_exp = exp_r;
    check_eq({tag, ".latency"}, 64'(got_lat), 64'(exp_lat));
    check_eq({tag, ".result"}, 64'(at_done), 64'(exp_r));
    check_eq({tag, ".hold"}, 64'(outs()), 64'(exp_r));
    check_eq({tag, ".done_pulses"}, 64'(dones), 64'd1);
    check_eq({tag, ".busy"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic no_match_req();
    int dones, busy_seen;
    dones = 0; busy_seen = 0;
    @(negedge clock);
    isMatching = 1'b0; start = 1'b1; matchCount = 5'd4; position = pv;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dones++;
      if (busy !== 1'b0) busy_seen++;
      @(negedge clock);
      start = 1'b0;
    end
    isMatching = 1'b1;
    check_eq("nomatch.done", 64'(dones), 64'd0);
    check_eq("nomatch.busy", 64'(busy_seen), 64'd0);
    check_eq("nomatch.hold", 64'(outs()), 64'(last_exp));
  endtask

  task automatic reset_mid();
    int dones;
    dones = 0;
    @(negedge clock);
    matchCount = 5'd4; position = pv; isMatching = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clock);
      start = 1'b0;
      @(posedge clock); #1;
      if (done === 1'b1) dones++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("rstmid.early_done", 64'(dones), 64'd0);
    check_eq("rstmid.outs", 64'(outs()), 64'd0);
    check_eq("rstmid.busy", 64'(busy), 64'd0);
    check_eq("rstmid.done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    last_exp = '0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int bad_pct;
    reset = 1'b1; start = 1'b0; isMatching = 1'b0; matchCount = '0;
    position = '0; pv = '0; last_exp = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset.outs", 64'(outs()), 64'd0);
    check_eq("reset.busy", 64'(busy), 64'd0);
    check_eq("reset.done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    fill_junk(); put_square();
    send_req("square", 5'd4, 0);

    fill_junk();
    send_req("cnt_reject", 5'd3, 0);

    fill_junk(); put_square();
    send_req("square2", 5'd4, 0);
    no_match_req();

    fill_junk();
    put(0, 1610); put(1, 1620); put(2, 19200); put(3, 3210); put(4, 3220);
    send_req("inv_one", 5'd5, 0);

    put(3, 32767);
    send_req("inv_two", 5'd5, 0);

    fill_junk();
    put(0, 0); put(1, 1); put(2, 1); put(3, 1);
    send_req("trunc", 5'd4, 0);

    for (int i = 0; i < 16; i++) put(i, 12079);
    send_req("clamp", 5'd20, 0);

    fill_junk(); put_square();
    send_req("start_busy", 5'd4, 30);

    reset_mid();
    send_req("after_reset", 5'd4, 0);

    for (int r = 0; r < 24; r++) begin
      bad_pct = (r % 4 == 0) ? 70 : 10;
      for (int i = 0; i < 16; i++) begin
        if (int'($urandom_range(0, 99)) < bad_pct) put(i, int'($urandom_range(19200, 32767)));
        else                                       put(i, int'($urandom_range(0, 19199)));
      end
      send_req($sformatf("rand%0d", r), 5'($urandom_range(0, 20)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mat_centroid.md
Name: mat_centroid

Overview:
- Downstream stage of the matching top level. Consumes the packed 16-entry matched-feature address vector and the match result.
- Converts each valid frame-buffer address (row-major, 160x120 frame) to x/y.
- Computes the centroid of the matched points and its signed offset from the frame centre.
- Feeds the flight-control correction logic.

Parameters:
FRAME_W, 160, frame width in pixels; address = y*FRAME_W + x
FRAME_H, 120, frame height in pixels
ADDR_W, 15, frame-buffer address width
MAX_PTS, 16, number of entries in the position vector
MIN_PTS, 4, minimum number of valid points for an accepted centroid

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
isMatching  input  1  match result; start is accepted only when it is 1
matchCount  input  5  number of filled entries; values >16 clamp to 16
position  input  240  entry i = position[15*i+14:15*i], i=0..15
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at the end of every accepted request
posValid  output  1  1 = centroid accepted; held until the next accepted start
centroidX  output  8  mean x, truncated
centroidY  output  7  mean y, truncated
offsetX  output  9  signed, centroidX - FRAME_W/2
offsetY  output  8  signed, centroidY - FRAME_H/2

Behaviour:
- Reset: synchronous, active-high; takes priority over everything, including mid-operation. FSM goes to IDLE; all outputs and internal sums/indices go to 0; a divide in flight is abandoned.
- Start acceptance: start & isMatching in IDLE. start while busy, or with isMatching=0, is ignored with no done pulse.
- FSM states:
  - IDLE
  - LOAD (1 cycle): latch position and clamped n; clear sumX, sumY, validCnt and idx. Go to CONV if n >= MIN_PTS, else to DONE with posValid=0.
  - CONV: issue an address/FRAME_W divide for entry idx. The divider takes ADDR_W cycles (done at issue+15). In the done cycle:
    - if address < FRAME_W*FRAME_H: sumY += quotient, sumX += remainder, validCnt++; otherwise the entry is skipped.
    - idx++; reissue on the next cycle, or go to AVGX when idx==n.
    - Each entry costs 16 cycles.
  - AVGX: if validCnt < MIN_PTS, go to DONE with posValid=0. Otherwise sumX/validCnt on a 12-bit divide (1 issue + 12 cycles).
  - AVGY: sumY/validCnt, same 13 cycles.
  - DONE (1 cycle): pulse done; register centroid, offsets and posValid; return to IDLE.
- Widths: sumX 12 bits (max 16*159=2544); sumY 11 bits (max 1904). Divisor is never 0 because MIN_PTS >= 1.
- Truncating division only, no rounding.
- Offsets are computed in 2's complement from the registered centroid.
- Latency, with start sampled at edge 0:
  - accepted centroid: done at edge 16n+27;
  - count reject (n < MIN_PTS): done at edge 2;
  - invalid-entry reject: done at edge 16n+2.
- On reject: centroid/offset outputs go to 0 and posValid=0.
- Between requests all result outputs hold their values.

Decomposition:
- Shared package mat_pkg:
  - FRAME_W, FRAME_H, ADDR_W, MAX_PTS, MIN_PTS constants;
  - state enum (IDLE, LOAD, CONV, AVGX, AVGY, DONE);
  - entry-extract helper.
- One sub-module, mat_seqdiv: parameterised restoring divider (W-bit dividend, start/done, quotient/remainder, W cycles). It is instantiated once and time-shared between CONV, AVGX and AVGY.

Test Plan:
- Square case: addresses 1610, 1620, 3210, 3220 (x 10/20, y 10/20), n=4, start -> done at edge 91; centroid (15,15); offset (-65,-45); posValid=1; busy high edges 1..90.
- Count reject: n=3, any addresses -> done at edge 2, posValid=0, all result outputs 0; a start with isMatching=0 -> no done, busy stays 0.
- Invalid entry: n=5 with entry 2 = 19200 and the other four as in the square case -> entry skipped, validCnt=4, centroid (15,15), done at edge 107. Repeat with two invalid entries -> posValid=0 at edge 82.
- Truncation and clamping: x = 0,1,1,1, y=0 (addresses 0,1,1,1), n=4 -> centroidX 0, offsetX -80. matchCount=20 with 16 entries of address 12079 (x=79, y=75) -> n clamps to 16, centroid (79,75), offset (-1,+15), done at edge 283.
- Start while busy: second start at edge 30 is ignored; exactly one done pulse.
- Reset at edge 40 of an accepted run -> next edge: IDLE, all outputs 0. A fresh start then completes normally with the square-case values.
